// File: rtl/pipe_pkg.sv
// Shared encodings and instruction field positions for the EX/WB pipeline controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] OP_JMP = 2'b11;

  // Register fields sit at fixed low positions; the opcode is always the top two bits.
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath-facing signal bundle of the pipeline controller.
interface pipe_ctrl_if #(
  parameter int INST_W = 8,
  parameter int CNT_W  = 16
);
  logic [INST_W-1:0] inst_code_ex;
  logic [INST_W-1:0] inst_code_wb;
  logic              RegWrite_wb;
  logic              stall_req;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              PCsrc;
  logic              RegWrite_ex;
  logic              Sel2;
  logic [1:0]        state;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    output inst_code_ex, inst_code_wb, RegWrite_wb, stall_req,
    input  pc_write, ifid_write, ifid_flush, PCsrc, RegWrite_ex, Sel2, state, retired_cnt
  );

  modport slave (
    input  inst_code_ex, inst_code_wb, RegWrite_wb, stall_req,
    output pc_write, ifid_write, ifid_flush, PCsrc, RegWrite_ex, Sel2, state, retired_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_fwd.sv
// WB->EX forwarding detect: the WB destination matches the EX rs operand.
module hazard_fwd
  import pipe_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic [1:0] i_op_ex,
  input  logic [2:0] i_rs_ex,
  input  logic [1:0] i_op_wb,
  input  logic [2:0] i_rd_wb,
  input  logic       i_regwrite_wb,
  output logic       o_sel2
);

  assign o_sel2 = i_ex_valid && i_regwrite_wb &&
                  (i_op_wb != OP_JMP) && (i_op_ex != OP_JMP) &&
                  (i_rd_wb == i_rs_ex);

endmodule

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the two-stage EX/WB pipeline: jump flush, external
// stall, write-enable decode, forwarding select and retired-instruction count.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int INST_W       = 8,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ex_valid;
  logic             w_next_ex_valid;
  logic [1:0]       r_flush_cnt;
  logic [1:0]       w_next_flush_cnt;
  logic [CNT_W-1:0] r_retired_cnt;

  logic [1:0] w_op_ex;
  logic [1:0] w_op_wb;
  logic       w_jmp;
  logic       w_wr;
  logic       w_pc_write;
  logic       w_ifid_write;
  logic       w_ifid_flush;
  logic       w_pcsrc;
  logic       w_regwrite_ex;
  logic       w_unused_bits;

  assign w_op_ex = bus.inst_code_ex[INST_W-1 -: 2];
  assign w_op_wb = bus.inst_code_wb[INST_W-1 -: 2];
  assign w_jmp   = r_ex_valid && (w_op_ex == OP_JMP);
  assign w_wr    = r_ex_valid && (w_op_ex != OP_JMP);

  // EX rd and WB rs take no part in control decisions.
  assign w_unused_bits = ^{bus.inst_code_ex[RD_MSB:RD_LSB], bus.inst_code_wb[RS_MSB:RS_LSB]};

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state     = r_state;
    w_next_ex_valid  = r_ex_valid;
    w_next_flush_cnt = r_flush_cnt;
    w_pc_write       = 1'b1;
    w_ifid_write     = 1'b1;
    w_ifid_flush     = 1'b0;
    w_pcsrc          = 1'b1;
    w_regwrite_ex    = 1'b0;

    unique case (r_state)
      RUN: begin
        w_regwrite_ex = w_wr;
        w_pcsrc       = ~w_jmp;
        w_ifid_flush  = w_jmp;
        if (w_jmp) begin
          w_next_state     = FLUSH;
          w_next_flush_cnt = FLUSH_INIT;
          w_next_ex_valid  = 1'b0;
        end else begin
          w_next_ex_valid = 1'b1;
          if (bus.stall_req) w_next_state = STALL;
        end
      end
      STALL: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        if (!bus.stall_req) w_next_state = RUN;
      end
      FLUSH: begin
        if (r_flush_cnt == 2'd0) begin
          w_next_state    = RUN;
          w_next_ex_valid = 1'b1;
        end else begin
          w_next_flush_cnt = r_flush_cnt - 2'd1;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RUN;
      r_ex_valid    <= 1'b0;
      r_flush_cnt   <= 2'd0;
      r_retired_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_ex_valid  <= w_next_ex_valid;
      r_flush_cnt <= w_next_flush_cnt;
      if (r_state == RUN && r_ex_valid) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  hazard_fwd u_hazard_fwd (
    .i_ex_valid    (r_ex_valid),
    .i_op_ex       (w_op_ex),
    .i_rs_ex       (bus.inst_code_ex[RS_MSB:RS_LSB]),
    .i_op_wb       (w_op_wb),
    .i_rd_wb       (bus.inst_code_wb[RD_MSB:RD_LSB]),
    .i_regwrite_wb (bus.RegWrite_wb),
    .o_sel2        (bus.Sel2)
  );

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.PCsrc       = w_pcsrc;
  assign bus.RegWrite_ex = w_regwrite_ex;
  assign bus.state       = r_state;
  assign bus.retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed sequences on two parameterisations, a Sel2 vector
// table, and a randomized run compared against a cycle-level reference model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] inst_ex = 8'h51;
  logic [7:0] inst_wb = 8'h00;
  logic       rw_wb = 1'b0;
  logic       stall = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl_if #(.INST_W(8), .CNT_W(16)) bus1 ();
  pipe_ctrl_if #(.INST_W(8), .CNT_W(4))  bus2 ();

  assign bus1.inst_code_ex = inst_ex;
  assign bus1.inst_code_wb = inst_wb;
  assign bus1.RegWrite_wb  = rw_wb;
  assign bus1.stall_req    = stall;
  assign bus2.inst_code_ex = inst_ex;
  assign bus2.inst_code_wb = inst_wb;
  assign bus2.RegWrite_wb  = rw_wb;
  assign bus2.stall_req    = stall;

  pipe_ctrl #(.INST_W(8), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  pipe_ctrl #(.INST_W(8), .FLUSH_CYCLES(3), .CNT_W(4))  u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pc_write"},    32'(bus1.pc_write),    1);
    check({tag, " ifid_write"},  32'(bus1.ifid_write),  1);
    check({tag, " ifid_flush"},  32'(bus1.ifid_flush),  0);
    check({tag, " PCsrc"},       32'(bus1.PCsrc),       1);
    check({tag, " RegWrite_ex"}, 32'(bus1.RegWrite_ex), 0);
    check({tag, " Sel2"},        32'(bus1.Sel2),        0);
    check({tag, " state"},       32'(bus1.state),       0);
    check({tag, " retired"},     32'(bus1.retired_cnt), 0);
  endtask

  typedef struct {
    logic [7:0] ex;
    logic [7:0] wb;
    logic       rw;
    logic       sel2;
  } sel_vec_t;

  sel_vec_t tbl [8];

  // Reference model: operating mode, flush bubbles still owed, validity of EX.
  localparam int M_RUN = 0, M_HOLD = 1, M_BUBBLE = 2;
  int          m_mode;
  int          m_left;
  bit          m_valid;
  logic [15:0] m_count;

  initial begin
    tbl[0] = '{8'h4A, 8'h51, 1'b1, 1'b1};
    tbl[1] = '{8'h4B, 8'h51, 1'b1, 1'b0};
    tbl[2] = '{8'h4A, 8'h51, 1'b0, 1'b0};
    tbl[3] = '{8'hCA, 8'h51, 1'b1, 1'b0};
    tbl[4] = '{8'h4A, 8'hD1, 1'b1, 1'b0};
    tbl[5] = '{8'h02, 8'h10, 1'b1, 1'b1};
    tbl[6] = '{8'h87, 8'hB8, 1'b1, 1'b1};
    tbl[7] = '{8'h87, 8'hB0, 1'b1, 1'b0};

    // Reset state, then first cycles after release.
    #1;
    check_reset_outputs("reset");
    repeat (2) cyc();
    reset = 1'b1;
    #1;
    check("c0 RegWrite_ex", 32'(bus1.RegWrite_ex), 0);
    check("c0 retired",     32'(bus1.retired_cnt), 0);
    cyc(); #1;
    check("c1 RegWrite_ex", 32'(bus1.RegWrite_ex), 1);
    check("c1 PCsrc",       32'(bus1.PCsrc),       1);
    check("c1 retired",     32'(bus1.retired_cnt), 0);
    cyc(); #1;
    check("c2 retired",     32'(bus1.retired_cnt), 1);

    // Stall for three edges.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check($sformatf("stall%0d state", i),       32'(bus1.state),       1);
      check($sformatf("stall%0d pc_write", i),    32'(bus1.pc_write),    0);
      check($sformatf("stall%0d ifid_write", i),  32'(bus1.ifid_write),  0);
      check($sformatf("stall%0d RegWrite_ex", i), 32'(bus1.RegWrite_ex), 0);
      check($sformatf("stall%0d retired", i),     32'(bus1.retired_cnt), 2);
    end
    stall = 1'b0;
    cyc(); #1;
    check("unstall state",       32'(bus1.state),       0);
    check("unstall RegWrite_ex", 32'(bus1.RegWrite_ex), 1);
    check("unstall retired",     32'(bus1.retired_cnt), 2);
    cyc(); #1;
    check("unstall retired+1",   32'(bus1.retired_cnt), 3);

    // Sel2 vectors applied while the FSM is parked in STALL with a valid EX.
    stall = 1'b1;
    cyc(); #1;
    check("sel park state", 32'(bus1.state), 1);
    for (int i = 0; i < 8; i++) begin
      inst_ex = tbl[i].ex;
      inst_wb = tbl[i].wb;
      rw_wb   = tbl[i].rw;
      #1;
      check($sformatf("sel2 vec%0d", i), 32'(bus1.Sel2), 32'(tbl[i].sel2));
      cyc();
    end
    inst_ex = 8'h51; inst_wb = 8'h00; rw_wb = 1'b0; stall = 1'b0;
    cyc(); #1;
    check("post-sel state",   32'(bus1.state),       0);
    check("post-sel retired", 32'(bus1.retired_cnt), 4);

    // Taken jump, FLUSH_CYCLES=1 on dut1 and 3 on dut2.
    inst_ex = 8'hC5;
    #1;
    check("jmp PCsrc",       32'(bus1.PCsrc),       0);
    check("jmp ifid_flush",  32'(bus1.ifid_flush),  1);
    check("jmp RegWrite_ex", 32'(bus1.RegWrite_ex), 0);
    check("jmp pc_write",    32'(bus1.pc_write),    1);
    cyc();
    inst_ex = 8'h4A; inst_wb = 8'h51; rw_wb = 1'b1;
    #1;
    check("flush state",       32'(bus1.state),       2);
    check("flush RegWrite_ex", 32'(bus1.RegWrite_ex), 0);
    check("flush PCsrc",       32'(bus1.PCsrc),       1);
    check("flush ifid_flush",  32'(bus1.ifid_flush),  0);
    check("flush Sel2 bubble", 32'(bus1.Sel2),        0);
    check("flush retired",     32'(bus1.retired_cnt), 5);
    check("dut2 flush j1",     32'(bus2.state),       2);
    cyc(); #1;
    check("after flush state",       32'(bus1.state),       0);
    check("after flush RegWrite_ex", 32'(bus1.RegWrite_ex), 1);
    check("after flush Sel2",        32'(bus1.Sel2),        1);
    check("dut2 flush j2",           32'(bus2.state),       2);
    inst_ex = 8'h51; inst_wb = 8'h00; rw_wb = 1'b0;
    cyc(); #1;
    check("dut2 flush j3",  32'(bus2.state),       2);
    check("retired after",  32'(bus1.retired_cnt), 6);
    cyc(); #1;
    check("dut2 flush end", 32'(bus2.state),       0);

    // Jump with a simultaneous stall request.
    inst_ex = 8'hC5; stall = 1'b1;
    #1;
    check("jmp+stall ifid_flush", 32'(bus1.ifid_flush), 1);
    cyc();
    inst_ex = 8'h51;
    #1;
    check("jmp+stall flush first", 32'(bus1.state),    2);
    check("jmp+stall pc_write",    32'(bus1.pc_write), 1);
    cyc(); #1;
    check("jmp+stall back RUN",    32'(bus1.state),    0);
    cyc(); #1;
    check("jmp+stall then STALL",  32'(bus1.state),    1);
    stall = 1'b0;
    cyc(); #1;
    check("jmp+stall resume",      32'(bus1.state),    0);

    // Asynchronous reset in the middle of a 3-cycle flush.
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    inst_ex = 8'hC5;
    cyc();
    inst_ex = 8'h51;
    #1;
    check("dut2 pre-rst flush a", 32'(bus2.state), 2);
    cyc(); #1;
    check("dut2 pre-rst flush b", 32'(bus2.state), 2);
    #2;
    reset = 1'b0;
    #1;
    check("rst-flush dut2 state",    32'(bus2.state),       0);
    check("rst-flush dut2 pc_write", 32'(bus2.pc_write),    1);
    check("rst-flush dut2 PCsrc",    32'(bus2.PCsrc),       1);
    check("rst-flush dut2 retired",  32'(bus2.retired_cnt), 0);
    check_reset_outputs("rst-flush dut1");

    // Asynchronous reset in the middle of a stall.
    cyc();
    reset = 1'b1;
    cyc();
    stall = 1'b1;
    cyc(); #1;
    check("pre-rst stall state", 32'(bus1.state), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst-stall");
    stall = 1'b0;

    // Counter wrap on the 4-bit instance.
    cyc();
    reset = 1'b1;
    repeat (16) cyc();
    #1;
    check("dut2 retired max",  32'(bus2.retired_cnt), 15);
    cyc(); #1;
    check("dut2 retired wrap", 32'(bus2.retired_cnt), 0);
    check("dut1 retired 16",   32'(bus1.retired_cnt), 16);

    // Randomized run against the reference model.
    #2;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    m_mode = M_RUN; m_left = 0; m_valid = 1'b0; m_count = 16'h0;
    for (int i = 0; i < 300; i++) begin
      bit jmp;
      bit e_pcw, e_ifw, e_rw, e_pcsrc, e_flush, e_sel2;
      inst_ex = 8'($urandom);
      inst_wb = 8'($urandom);
      rw_wb   = 1'($urandom);
      stall   = ($urandom_range(3) == 0);
      #1;
      jmp = m_valid && (inst_ex[7:6] == 2'b11);
      e_pcw = (m_mode != M_HOLD);
      e_ifw = (m_mode != M_HOLD);
      e_rw    = (m_mode == M_RUN) && m_valid && !jmp;
      e_pcsrc = !((m_mode == M_RUN) && jmp);
      e_flush = (m_mode == M_RUN) && jmp;
      e_sel2  = m_valid && rw_wb && (inst_ex[7:6] != 2'b11) && (inst_wb[7:6] != 2'b11) &&
                (inst_wb[5:3] == inst_ex[2:0]);
      check($sformatf("rnd%0d pc_write", i),    32'(bus1.pc_write),    32'(e_pcw));
      check($sformatf("rnd%0d ifid_write", i),  32'(bus1.ifid_write),  32'(e_ifw));
      check($sformatf("rnd%0d RegWrite_ex", i), 32'(bus1.RegWrite_ex), 32'(e_rw));
      check($sformatf("rnd%0d PCsrc", i),       32'(bus1.PCsrc),       32'(e_pcsrc));
      check($sformatf("rnd%0d ifid_flush", i),  32'(bus1.ifid_flush),  32'(e_flush));
      check($sformatf("rnd%0d Sel2", i),        32'(bus1.Sel2),        32'(e_sel2));
      check($sformatf("rnd%0d state", i),       32'(bus1.state),       32'(m_mode));
      check($sformatf("rnd%0d retired", i),     32'(bus1.retired_cnt), 32'(m_count));
      if (m_mode == M_RUN) begin
        if (m_valid) m_count = m_count + 16'd1;
        if (jmp) begin
          m_mode = M_BUBBLE; m_left = 1; m_valid = 1'b0;
        end else begin
          m_valid = 1'b1;
          if (stall) m_mode = M_HOLD;
        end
      end else if (m_mode == M_HOLD) begin
        if (!stall) m_mode = M_RUN;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = M_RUN; m_valid = 1'b1;
        end
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Sequencing controller for the two-stage EX/WB pipeline of the 8-bit core.
- Decodes the instruction held in EX and generates:
  - PC and IF/ID write enables, plus the IF/ID flush.
  - RegWrite_exwb_in and Sel2 for the EX/WB register.
  - PCsrc.
- Owns the jump-flush and external-stall state machine and the instruction-valid/retire bookkeeping; the datapath registers themselves stay dumb.

Parameters:
- INST_W, 8, instruction width; opcode = [INST_W-1:INST_W-2], rd = [5:3], rs = [2:0] (target = [5:0] for jumps).
- FLUSH_CYCLES, 1, bubble cycles after a taken jump (legal range 1..3).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- inst_code_ex  in  INST_W  instruction currently in EX (IF/ID register output).
- inst_code_wb  in  INST_W  instruction in WB (EX/WB inst_code output).
- RegWrite_wb  in  1  WB-stage write enable (EX/WB RegWrite output).
- stall_req  in  1  external hold request (e.g. multi-cycle memory).
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  marks the instruction being loaded into IF/ID as a bubble.
- PCsrc  out  1  1 = PC+1, 0 = jump target.
- RegWrite_ex  out  1  drives RegWrite_exwb_in.
- Sel2  out  1  forward ALU result from WB to EX rs operand.
- state  out  2  current FSM state (debug).
- retired_cnt  out  CNT_W  valid instructions leaving EX.

Behaviour:
- Interface:
  - One clock `clk`.
  - `reset` asynchronous active-low; all registers clear immediately on the falling edge of `reset`, independent of `clk`.
- Registers:
  - state (RUN=0, STALL=1, FLUSH=2)
  - ex_valid
  - flush_cnt (2 bits)
  - retired_cnt
- Reset values:
  - state=RUN, ex_valid=0, flush_cnt=0, retired_cnt=0.
  - Resulting outputs: pc_write=1, ifid_write=1, ifid_flush=0, PCsrc=1, RegWrite_ex=0, Sel2=0.
- Decode (combinational): jmp = ex_valid & (opcode==2'b11); wr = ex_valid & (opcode!=2'b11).
- RUN:
  - Outputs:
    - pc_write=1, ifid_write=1.
    - RegWrite_ex=wr.
    - PCsrc=~jmp, ifid_flush=jmp.
  - Transitions:
    - If jmp: next FLUSH, flush_cnt<=FLUSH_CYCLES-1, ex_valid<=0.
    - Else if stall_req: next STALL, ex_valid<=1.
    - Else: stay RUN, ex_valid<=1.
  - Jump has priority over stall_req in the same cycle; the stall is re-sampled once back in RUN.
- STALL:
  - Outputs: pc_write=0, ifid_write=0, RegWrite_ex=0 (bubble to WB), PCsrc=1, ifid_flush=0.
  - ex_valid holds.
  - Exit to RUN on the first edge where stall_req=0; entry and exit latency is one cycle each.
  - Jumps in EX are not evaluated while in STALL.
- FLUSH:
  - Outputs: pc_write=1, ifid_write=1, PCsrc=1, RegWrite_ex=0, ifid_flush=0.
  - ex_valid stays 0.
  - When flush_cnt==0: next RUN, ex_valid<=1; otherwise flush_cnt decrements.
  - stall_req is ignored in FLUSH.
- Sel2:
  - Sel2 = ex_valid & RegWrite_wb & (inst_code_wb opcode!=11) & (opcode!=11) & (inst_code_wb[5:3]==inst_code_ex[2:0]).
  - Combinational, valid in every state; forced 0 when ex_valid=0.
- retired_cnt:
  - Increments by 1 on each edge where state==RUN and ex_valid=1 (jumps included).
  - Wraps modulo 2^CNT_W.
- Reset mid-flush or mid-stall returns immediately to the reset values.
- The first post-reset RUN cycle is treated as a bubble because ex_valid=0.

Decomposition:
- Package pipe_pkg:
  - State encodings RUN/STALL/FLUSH.
  - OP_JMP=2'b11.
  - Field position constants for opcode/rd/rs.
- Sub-module hazard_fwd: the combinational Sel2 comparator, reusable by a future second forward path.
- FSM, counters, and enable decode stay in pipe_ctrl.

Test Plan:
- Reset then release with inst_code_ex=0x51:
  - Cycle 0: RegWrite_ex=0, retired_cnt=0.
  - From cycle 1: RegWrite_ex=1, PCsrc=1; retired_cnt=1 after that edge.
- inst_code_wb=0x51 (rd=2), RegWrite_wb=1, inst_code_ex=0x4A (rs=2) -> Sel2=1. Change rs to 3 (0x4B) -> Sel2=0. Set RegWrite_wb=0 -> Sel2=0.
- inst_code_ex=0xC5 in RUN with FLUSH_CYCLES=1:
  - Jump cycle: PCsrc=0, ifid_flush=1, RegWrite_ex=0.
  - Next cycle: state=FLUSH, RegWrite_ex=0.
  - Following cycle: state=RUN, ex_valid=1.
- stall_req=1 for 3 cycles:
  - STALL for 3 cycles with pc_write=ifid_write=RegWrite_ex=0; retired_cnt frozen.
  - RUN resumes one cycle after stall_req falls.
- Jump and stall_req=1 in the same cycle:
  - FLUSH entered first.
  - STALL entered on the first RUN cycle afterwards if stall_req is still 1.
- Assert reset low mid-FLUSH (FLUSH_CYCLES=3) and mid-STALL:
  - Outputs return to reset values asynchronously.
  - Preload retired_cnt to 0xFFFF, retire one instruction -> retired_cnt wraps to 0x0000.
